nfu_serial_ctrl: RTL and testbench
==================================

# nfu_serial_ctrl

Sequencer for the bit-serial NFU-1-2 array (Tw windows x Tn filters of serial inner-product tiles). Accepts a job of K neuron/synapse bricks at a programmable precision and loads synapses once per brick. Drives the neuron bit-slices MSB-first and generates the first-cycle, load and max strobes the datapath consumes. Covers the adder-tree pipeline latency and schedules NBout read/write of partial sums; sits between the NB/SB buffer controllers and the datapath.

## Interface
- Tw, 16, windows per tile row; width of o_load
- KW, 8, width of brick-count field
- PIPE_LAT, 1, adder-tree pipeline registers between neuron input and accumulator input
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_start  in  1  one-cycle job request; ignored unless o_busy=0
- i_precision  in  5  bits per neuron (1..16); 0 or >16 treated as 16
- i_num_bricks  in  KW  bricks in job (K); 0 = empty job
- i_max  in  1  max-pooling job; captured at start
- i_fc  in  1  FC mode: per-window synapse load; captured at start
- i_sb_avail  in  1  SB has the next synapse brick (or window slice in FC)
- i_nb_avail  in  1  NB holds all P bit-slices of the next neuron brick
- o_sb_rd  out  1  pop one synapse brick/slice
- o_nb_rd  out  1  pop one neuron bit-slice
- o_load  out  Tw  per-window synapse latch enable
- o_first_cycle  out  1  MSB bit-slice on datapath inputs
- o_bit_idx  out  5  current bit-slice, 0 = MSB
- o_nbout_rd  out  1  NBout partial sum needed by datapath this cycle
- o_max  out  1  datapath max-compare enable
- o_nbout_wr  out  1  datapath output valid; write NBout
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse at job end

## Operation
- Config (P, K, max, fc) registered on accepted i_start; later changes to inputs have no effect.
- States: IDLE, LOAD, BITS, DRAIN, DONE.
- IDLE: o_busy=0. On i_start: K=0 -> DONE; else LOAD, brick counter k=0.
- LOAD, conv (fc=0): wait until i_sb_avail & i_nb_avail. In that cycle: o_load = all ones, o_sb_rd=1; next state BITS.
- LOAD, fc=1: window index w walks 0..Tw-1. Each cycle with i_sb_avail: o_load = one-hot w, o_sb_rd=1, w++. Stalls otherwise. After w=Tw-1 is loaded, enter BITS once i_nb_avail is seen (may wait).
- BITS: exactly P consecutive cycles; never stalls. o_nb_rd=1 and o_bit_idx=b for b=0..P-1.
- BITS bit 0: o_first_cycle=1 and o_nbout_rd=1.
- DRAIN: PIPE_LAT+1 cycles, o_nb_rd=0. On the last drain cycle: o_nbout_wr=1, and o_max=max-cfg. Then k++.
- DRAIN exit: if k==K go to DONE, else LOAD.
- DONE: o_done=1 for one cycle, then IDLE.
- o_max low in all other cycles.
- Counters: bit counter 5 bits; brick counter KW bits with compare on k==K (no wrap, so K=2^KW-1 runs correctly).

## Timing
- Reset (async assert): state IDLE; all outputs 0 including o_load; counters cleared. Reset mid-job abandons the job with no o_done. First action after release needs a fresh i_start.
- i_start sampled at edge; LOAD is the following cycle. i_start while busy is dropped, no queueing.
- Per brick, conv, no stalls: 1 + P + PIPE_LAT + 1 cycles.
- Job with i_start in cycle 0: o_done in cycle 1 + K*(P+PIPE_LAT+2).
- Empty job (K=0): o_done in cycle 1; no strobes issued.
- o_nbout_wr occurs PIPE_LAT+1 cycles after the last bit cycle (tree latency plus accumulator register).
- All outputs are registered-state decodes; no combinational path from *_avail to o_load/o_nb_rd beyond the current-state AND.
- Simultaneous i_start and reset: reset wins.

## Test plan
- Reset: assert reset asynchronously mid-BITS (P=8, K=3, cycle 5) -> all outputs 0 immediately; no o_done; subsequent start runs normally.
- Conv, P=4, K=2, PIPE_LAT=1, avail high, start cycle 0 -> LOAD cycles 1, 8; o_first_cycle cycles 2, 9; o_nb_rd cycles 2-5 and 9-12; o_nbout_wr cycles 7, 14; o_done cycle 15.
- Precision clamp: i_precision=0 and then 20 with K=1 -> 16 o_nb_rd cycles each, o_bit_idx 0..15.
- Stalls, conv: i_nb_avail low for 3 cycles after start -> LOAD held 4 cycles, single o_sb_rd; BITS still exactly P contiguous cycles.
- FC, Tw=16, i_sb_avail toggling 1,0 -> o_load one-hot 0x0001..0x8000 on alternate cycles; 16 o_sb_rd pulses before BITS.
- Max mode, K=1, P=2 -> o_max=1 only in the o_nbout_wr cycle; i_start during busy and K=0 job -> ignored / o_done the cycle after start.

Source files
------------

// File: rtl/nfu_serial_ctrl.sv
// Job sequencer for the bit-serial NFU-1-2 array: per-brick synapse load, MSB-first
// neuron bit-slice issue, adder-tree drain and NBout read/write strobes.
module nfu_serial_ctrl #(
  parameter int Tw       = 16,
  parameter int KW       = 8,
  parameter int PIPE_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [4:0]    i_precision,
  input  logic [KW-1:0] i_num_bricks,
  input  logic          i_max,
  input  logic          i_fc,
  input  logic          i_sb_avail,
  input  logic          i_nb_avail,
  output logic          o_sb_rd,
  output logic          o_nb_rd,
  output logic [Tw-1:0] o_load,
  output logic          o_first_cycle,
  output logic [4:0]    o_bit_idx,
  output logic          o_nbout_rd,
  output logic          o_max,
  output logic          o_nbout_wr,
  output logic          o_busy,
  output logic          o_done
);

  localparam int WW = (Tw > 1) ? $clog2(Tw) : 1;
  localparam int DW = $clog2(PIPE_LAT + 2);

  typedef enum logic [2:0] {IDLE, LOAD, BITS, DRAIN, DONE} state_t;

  state_t        state;
  logic [4:0]    p_cfg;
  logic [KW-1:0] k_cfg;
  logic          max_cfg;
  logic          fc_cfg;
  logic [KW-1:0] k;
  logic [4:0]    b;
  logic [DW-1:0] d;
  logic [WW-1:0] w;
  logic          fc_loaded;

  logic          conv_go, fc_fire, fc_last, fc_go, bits_last, drain_last;
  logic [KW-1:0] k_nxt;

  // Every strobe is the current state ANDed with at most the avail inputs.
  assign conv_go    = (state == LOAD) && !fc_cfg && i_sb_avail && i_nb_avail;
  assign fc_fire    = (state == LOAD) && fc_cfg && !fc_loaded && i_sb_avail;
  assign fc_last    = fc_fire && (w == WW'(Tw - 1));
  assign fc_go      = (state == LOAD) && fc_cfg && (fc_loaded || fc_last) && i_nb_avail;
  assign bits_last  = (state == BITS) && (b == 5'(p_cfg - 5'd1));
  assign drain_last = (state == DRAIN) && (d == DW'(PIPE_LAT));
  assign k_nxt      = k + KW'(1);

  always_comb begin
    o_load = '0;
    if (conv_go)      o_load = '1;
    else if (fc_fire) o_load = Tw'(1) << w;
  end

  assign o_sb_rd       = conv_go || fc_fire;
  assign o_nb_rd       = (state == BITS);
  assign o_bit_idx     = (state == BITS) ? b : 5'd0;
  assign o_first_cycle = (state == BITS) && (b == 5'd0);
  assign o_nbout_rd    = o_first_cycle;
  assign o_nbout_wr    = drain_last;
  assign o_max         = drain_last && max_cfg;
  assign o_busy        = (state != IDLE);
  assign o_done        = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      p_cfg     <= '0;
      k_cfg     <= '0;
      max_cfg   <= 1'b0;
      fc_cfg    <= 1'b0;
      k         <= '0;
      b         <= '0;
      d         <= '0;
      w         <= '0;
      fc_loaded <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          p_cfg     <= (i_precision == 5'd0 || i_precision > 5'd16) ? 5'd16 : i_precision;
          k_cfg     <= i_num_bricks;
          max_cfg   <= i_max;
          fc_cfg    <= i_fc;
          k         <= '0;
          w         <= '0;
          fc_loaded <= 1'b0;
          state     <= (i_num_bricks == '0) ? DONE : LOAD;
        end
        LOAD: begin
          if (fc_fire) w <= w + WW'(1);
          if (fc_last) fc_loaded <= 1'b1;
          if (conv_go || fc_go) begin
            b     <= '0;
            state <= BITS;
          end
        end
        BITS: begin
          b <= b + 5'd1;
          if (bits_last) begin
            b     <= '0;
            d     <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          d <= d + DW'(1);
          if (drain_last) begin
            // k never exceeds K, so K = 2^KW-1 terminates without wrap.
            k         <= k_nxt;
            w         <= '0;
            fc_loaded <= 1'b0;
            state     <= (k_nxt == k_cfg) ? DONE : LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nfu_serial_ctrl.sv
// Directed bench for nfu_serial_ctrl: per-cycle strobe masks compared with hand-computed schedules.
module tb_nfu_serial_ctrl;
  localparam int TW = 16;
  localparam int KW = 8;
  localparam int PL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start, i_max, i_fc, i_sb_avail, i_nb_avail;
  logic [4:0]    i_precision;
  logic [KW-1:0] i_num_bricks;
  logic          o_sb_rd, o_nb_rd, o_first_cycle, o_nbout_rd, o_max, o_nbout_wr, o_busy, o_done;
  logic [TW-1:0] o_load;
  logic [4:0]    o_bit_idx;

  nfu_serial_ctrl #(.Tw(TW), .KW(KW), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_precision(i_precision),
    .i_num_bricks(i_num_bricks), .i_max(i_max), .i_fc(i_fc), .i_sb_avail(i_sb_avail),
    .i_nb_avail(i_nb_avail), .o_sb_rd(o_sb_rd), .o_nb_rd(o_nb_rd), .o_load(o_load),
    .o_first_cycle(o_first_cycle), .o_bit_idx(o_bit_idx), .o_nbout_rd(o_nbout_rd),
    .o_max(o_max), .o_nbout_wr(o_nbout_wr), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] r_sb, r_nb, r_first, r_nbrd, r_wr, r_max, r_done, r_busy, r_load_any;
  logic [15:0] r_load [64];
  int n_sb, n_sb_pre, n_nb, idx_err, first_nb;

  function automatic logic [28:0] all_outs();
    return {o_sb_rd, o_nb_rd, o_load, o_first_cycle, o_bit_idx, o_nbout_rd,
            o_max, o_nbout_wr, o_busy, o_done};
  endfunction

  // Cycle 0 carries i_start; config inputs are scrambled afterwards to prove capture.
  task automatic run_job(input logic [4:0] prec, input logic [KW-1:0] nbk, input logic mx,
                         input logic fc, input int ncyc, input int sb_mode, input int nb_low,
                         input int extra_start);
    int seq;
    int pe;
    seq = 0;
    pe = (prec == 5'd0 || prec > 5'd16) ? 16 : int'(prec);
    {r_sb, r_nb, r_first, r_nbrd, r_wr, r_max, r_done, r_busy, r_load_any} = '0;
    n_sb = 0; n_sb_pre = 0; n_nb = 0; idx_err = 0; first_nb = -1;
    for (int c = 0; c < ncyc; c++) begin
      i_start      = (c == 0) || (c == extra_start);
      i_precision  = (c == 0) ? prec : 5'd3;
      i_num_bricks = (c == 0) ? nbk : '0;
      i_max        = (c == 0) ? mx : ~mx;
      i_fc         = (c == 0) ? fc : ~fc;
      i_sb_avail   = (sb_mode == 1) ? (c % 2 == 1) : 1'b1;
      i_nb_avail   = !(c >= 1 && c <= nb_low);
      #1;
      r_sb[c] = o_sb_rd;         r_nb[c] = o_nb_rd;    r_first[c] = o_first_cycle;
      r_nbrd[c] = o_nbout_rd;    r_wr[c] = o_nbout_wr; r_max[c] = o_max;
      r_done[c] = o_done;        r_busy[c] = o_busy;   r_load[c] = o_load;
      r_load_any[c] = (o_load != '0);
      if (o_sb_rd) begin
        n_sb++;
        if (n_nb == 0) n_sb_pre++;
      end
      if (o_nb_rd) begin
        if (first_nb < 0) first_nb = c;
        if (o_bit_idx != seq[4:0]) idx_err++;
        seq = (seq + 1) % pe;
        n_nb++;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
  endtask

  initial begin
    int seen_done, seen_busy;
    reset = 1'b1; i_start = 1'b0; i_precision = '0; i_num_bricks = '0;
    i_max = 1'b0; i_fc = 1'b0; i_sb_avail = 1'b0; i_nb_avail = 1'b0;
    #2;
    check("reset_outs", 64'(all_outs()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-BITS: P=8, K=3, asserted in cycle 5 (bit 3)
    run_job(5'd8, 8'd3, 1'b0, 1'b0, 5, 0, 0, -1);
    #1;
    check("rst_pre_nb_rd", 64'(o_nb_rd), 64'd1);
    check("rst_pre_bit_idx", 64'(o_bit_idx), 64'd3);
    #2 reset = 1'b1;
    #1 check("rst_async_outs", 64'(all_outs()), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    seen_done = 0; seen_busy = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (o_done) seen_done++;
      if (o_busy) seen_busy++;
      @(posedge clk); #1;
    end
    check("rst_no_done", 64'(seen_done), 64'd0);
    check("rst_idle_busy", 64'(seen_busy), 64'd0);

    // Conv P=4 K=2, all avail
    run_job(5'd4, 8'd2, 1'b0, 1'b0, 20, 0, 0, -1);
    check("conv_sb_rd", r_sb, 64'h102);
    check("conv_load_cyc", r_load_any, 64'h102);
    check("conv_load_val", 64'(r_load[1]), 64'hFFFF);
    check("conv_nb_rd", r_nb, 64'h1E3C);
    check("conv_first", r_first, 64'h204);
    check("conv_nbout_rd", r_nbrd, 64'h204);
    check("conv_nbout_wr", r_wr, 64'h4080);
    check("conv_done", r_done, 64'h8000);
    check("conv_max", r_max, 64'h0);
    check("conv_busy", r_busy & 64'h7FFF, 64'h7FFE);
    check("conv_bit_idx", 64'(idx_err), 64'd0);

    // Precision clamp
    run_job(5'd0, 8'd1, 1'b0, 1'b0, 24, 0, 0, -1);
    check("p0_nb_cnt", 64'(n_nb), 64'd16);
    check("p0_bit_idx", 64'(idx_err), 64'd0);
    check("p0_done", r_done, 64'd1 << 20);
    run_job(5'd20, 8'd1, 1'b0, 1'b0, 24, 0, 0, -1);
    check("p20_nb_cnt", 64'(n_nb), 64'd16);
    check("p20_bit_idx", 64'(idx_err), 64'd0);
    check("p20_done", r_done, 64'd1 << 20);

    // Conv stall: nb_avail low cycles 1..3
    run_job(5'd4, 8'd1, 1'b0, 1'b0, 14, 0, 3, -1);
    check("stall_sb_rd", r_sb, 64'h10);
    check("stall_sb_cnt", 64'(n_sb), 64'd1);
    check("stall_load", r_load_any, 64'h10);
    check("stall_nb_rd", r_nb, 64'h1E0);
    check("stall_done", r_done, 64'h800);

    // FC, sb_avail high on odd cycles
    run_job(5'd2, 8'd1, 1'b0, 1'b1, 40, 1, 0, -1);
    check("fc_sb_pre", 64'(n_sb_pre), 64'd16);
    check("fc_sb_cnt", 64'(n_sb), 64'd16);
    check("fc_load_c1", 64'(r_load[1]), 64'h0001);
    check("fc_load_c2", 64'(r_load[2]), 64'h0000);
    check("fc_load_c3", 64'(r_load[3]), 64'h0002);
    check("fc_load_c31", 64'(r_load[31]), 64'h8000);
    check("fc_first_nb", 64'(first_nb), 64'd32);
    check("fc_nb_rd", r_nb, 64'h3 << 32);
    check("fc_done", r_done, 64'd1 << 36);

    // Max mode, with a dropped start while busy
    run_job(5'd2, 8'd1, 1'b1, 1'b0, 10, 0, 0, 3);
    check("max_max", r_max, 64'h20);
    check("max_wr", r_wr, 64'h20);
    check("max_done", r_done, 64'h40);

    // Empty job
    run_job(5'd4, 8'd0, 1'b0, 1'b0, 5, 0, 0, -1);
    check("k0_done", r_done, 64'h2);
    check("k0_sb", r_sb, 64'h0);
    check("k0_nb", r_nb, 64'h0);
    check("k0_load", r_load_any, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
